// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control sequencer slice:
//   - default address widths for instruction memory, data/coefficient RAM
//     and register file
//   - FSM state encoding used by ctrl_sequencer
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // Default widths; the modules and the interface take these as parameter defaults.
  localparam int DEF_IAWIDTH  = 6;
  localparam int DEF_DAWIDTH  = 12;
  localparam int DEF_RFAWIDTH = 5;

  // Sequencer states. Encoding is plain binary; IDLE is the reset state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DECODE = 3'd3,
    ST_MAC    = 3'd4,
    ST_WRITE  = 3'd5,
    ST_OUTPUT = 3'd6
  } state_t;

endpackage : ctrl_pkg

// File: rtl/ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer_if
// Bundles every non-clock/reset signal of the control sequencer.
//   master : the sequencer (drives control, fetch and RAM addresses)
//   slave  : the surrounding datapath / fetch stage / output consumer
// Signals:
//   start, busy                 sample kick-off and activity flag
//   imem_addr, fetch            instruction fetch address and strobe
//   lstg_f, upse_f, result_reg  decoded instruction flags and result register
//   data_uptr, data_lptr, coef_ptr  decoded pointers
//   dram_addr, cram_addr        data / coefficient RAM read addresses
//   mac_clr, mac_en             accumulator control
//   rf_we, rf_waddr             register file write port
//   out_valid, out_ready        output-sample handshake
// ---------------------------------------------------------------------------
interface ctrl_sequencer_if
  import ctrl_pkg::*;
#(
  parameter int IAWIDTH  = DEF_IAWIDTH,
  parameter int DAWIDTH  = DEF_DAWIDTH,
  parameter int RFAWIDTH = DEF_RFAWIDTH
);

  logic                start;
  logic                busy;
  logic [IAWIDTH-1:0]  imem_addr;
  logic                fetch;
  logic                lstg_f;
  logic                upse_f;
  logic [RFAWIDTH-1:0] result_reg;
  logic [DAWIDTH-1:0]  data_uptr;
  logic [DAWIDTH-1:0]  data_lptr;
  logic [DAWIDTH-1:0]  coef_ptr;
  logic [DAWIDTH-1:0]  dram_addr;
  logic [DAWIDTH-1:0]  cram_addr;
  logic                mac_clr;
  logic                mac_en;
  logic                rf_we;
  logic [RFAWIDTH-1:0] rf_waddr;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  start, lstg_f, upse_f, result_reg, data_uptr, data_lptr, coef_ptr, out_ready,
    output busy, imem_addr, fetch, dram_addr, cram_addr, mac_clr, mac_en,
           rf_we, rf_waddr, out_valid
  );

  modport slave (
    output start, lstg_f, upse_f, result_reg, data_uptr, data_lptr, coef_ptr, out_ready,
    input  busy, imem_addr, fetch, dram_addr, cram_addr, mac_clr, mac_en,
           rf_we, rf_waddr, out_valid
  );

endinterface : ctrl_sequencer_if

// File: rtl/ctrl_agen.sv
// ---------------------------------------------------------------------------
// ctrl_agen
// Address generator for the MAC loop.
//   load      : capture lower data pointer, coefficient pointer and tap count
//   step      : advance both addresses by one (modulo 2^DAWIDTH)
//   lptr/uptr/cptr : decoded lower/upper data pointer and coefficient pointer
//   dram_addr/cram_addr : registered read addresses
//   last_tap  : the current address pair is the final tap
// The tap count is (uptr - lptr) mod 2^DAWIDTH + 1, so it ranges 1..2^DAWIDTH
// and needs one extra bit. Because both start at lptr and move in lock-step,
// "remaining taps == 1" is the same cycle in which dram_addr equals uptr,
// including when the window wraps through the top of the address space.
// ---------------------------------------------------------------------------
module ctrl_agen
  import ctrl_pkg::*;
#(
  parameter int DAWIDTH = DEF_DAWIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [DAWIDTH-1:0] lptr,
  input  logic [DAWIDTH-1:0] uptr,
  input  logic [DAWIDTH-1:0] cptr,
  output logic [DAWIDTH-1:0] dram_addr,
  output logic [DAWIDTH-1:0] cram_addr,
  output logic               last_tap
);

  localparam logic [DAWIDTH-1:0] ADDR_ONE = {{(DAWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DAWIDTH:0]   TAP_ONE  = {{DAWIDTH{1'b0}}, 1'b1};

  logic [DAWIDTH-1:0] dram_addr_r;
  logic [DAWIDTH-1:0] cram_addr_r;
  logic [DAWIDTH:0]   tap_rem_r;
  logic [DAWIDTH-1:0] span_s;

  // Window span; natural unsigned wrap gives the modulo difference.
  assign span_s = uptr - lptr;

  // Address counters and remaining-tap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_addr_r <= '0;
      cram_addr_r <= '0;
      tap_rem_r   <= '0;
    end else if (load) begin
      dram_addr_r <= lptr;
      cram_addr_r <= cptr;
      tap_rem_r   <= {1'b0, span_s} + TAP_ONE;
    end else if (step && !last_tap) begin
      dram_addr_r <= dram_addr_r + ADDR_ONE;
      cram_addr_r <= cram_addr_r + ADDR_ONE;
      tap_rem_r   <= tap_rem_r - TAP_ONE;
    end else begin
      dram_addr_r <= dram_addr_r;
      cram_addr_r <= cram_addr_r;
      tap_rem_r   <= tap_rem_r;
    end
  end

  assign dram_addr = dram_addr_r;
  assign cram_addr = cram_addr_r;
  assign last_tap  = (tap_rem_r == TAP_ONE);

endmodule : ctrl_agen

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Program sequencer for a MAC-based filter engine. On start it walks the
// instruction memory from pc, and for each instruction runs N accumulate
// cycles over a (possibly wrapping) data/coefficient window, writes the
// result to the register file, optionally presents an output sample, and
// either moves to the next instruction or returns to IDLE with pc=0.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (forces IDLE, pc=0, outputs 0)
//   bus    ctrl_sequencer_if master modport (see interface for signals)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int IAWIDTH  = DEF_IAWIDTH,
  parameter int DAWIDTH  = DEF_DAWIDTH,
  parameter int RFAWIDTH = DEF_RFAWIDTH
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_sequencer_if.master bus
);

  localparam logic [IAWIDTH-1:0] PC_ONE = {{(IAWIDTH-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [IAWIDTH-1:0]  pc_r;
  logic                busy_r;
  logic                fetch_r;
  logic                mac_clr_r;
  logic                mac_en_r;
  logic                rf_we_r;
  logic                out_valid_r;
  logic [RFAWIDTH-1:0] result_r;
  logic                lstg_r;
  logic                upse_r;

  logic                agen_load_s;
  logic                agen_step_s;
  logic                last_tap_s;
  logic [DAWIDTH-1:0]  dram_addr_s;
  logic [DAWIDTH-1:0]  cram_addr_s;

  state_t              adv_state_s;
  logic [IAWIDTH-1:0]  adv_pc_s;
  logic                adv_fetch_s;
  logic                adv_busy_s;

  // Pointers are taken in DECODE so the first MAC cycle already shows lptr/cptr.
  assign agen_load_s = (state_r == ST_DECODE);
  assign agen_step_s = (state_r == ST_MAC);

  ctrl_agen #(
    .DAWIDTH (DAWIDTH)
  ) u_agen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (agen_load_s),
    .step      (agen_step_s),
    .lptr      (bus.data_lptr),
    .uptr      (bus.data_uptr),
    .cptr      (bus.coef_ptr),
    .dram_addr (dram_addr_s),
    .cram_addr (cram_addr_s),
    .last_tap  (last_tap_s)
  );

  // Program-counter advance shared by WRITE (no output) and OUTPUT (handshake done).
  always_comb begin
    adv_state_s = ST_IDLE;
    adv_pc_s    = '0;
    adv_fetch_s = 1'b0;
    adv_busy_s  = 1'b0;
    if (lstg_r) begin
      adv_state_s = ST_IDLE;
      adv_pc_s    = '0;
      adv_fetch_s = 1'b0;
      adv_busy_s  = 1'b0;
    end else begin
      adv_state_s = ST_FETCH;
      adv_pc_s    = pc_r + PC_ONE;
      adv_fetch_s = 1'b1;
      adv_busy_s  = 1'b1;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= '0;
      busy_r      <= 1'b0;
      fetch_r     <= 1'b0;
      mac_clr_r   <= 1'b0;
      mac_en_r    <= 1'b0;
      rf_we_r     <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      lstg_r      <= 1'b0;
      upse_r      <= 1'b0;
    end else begin
      // Single-cycle strobes fall unless a state below re-asserts them.
      fetch_r   <= 1'b0;
      mac_clr_r <= 1'b0;
      mac_en_r  <= 1'b0;
      rf_we_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_FETCH;
            fetch_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOAD;
        end
        // Covers the synchronous IMEM read and the fetch-stage register.
        ST_LOAD: begin
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          result_r  <= bus.result_reg;
          lstg_r    <= bus.lstg_f;
          upse_r    <= bus.upse_f;
          mac_clr_r <= 1'b1;
          mac_en_r  <= 1'b1;
          state_r   <= ST_MAC;
        end
        ST_MAC: begin
          if (last_tap_s) begin
            rf_we_r <= 1'b1;
            state_r <= ST_WRITE;
          end else begin
            mac_en_r <= 1'b1;
            state_r  <= ST_MAC;
          end
        end
        ST_WRITE: begin
          if (upse_r) begin
            out_valid_r <= 1'b1;
            state_r     <= ST_OUTPUT;
          end else begin
            state_r <= adv_state_s;
            pc_r    <= adv_pc_s;
            fetch_r <= adv_fetch_s;
            busy_r  <= adv_busy_s;
          end
        end
        // out_valid is already high in the first OUTPUT cycle, so a ready
        // seen in that cycle completes the handshake immediately.
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= adv_state_s;
            pc_r        <= adv_pc_s;
            fetch_r     <= adv_fetch_s;
            busy_r      <= adv_busy_s;
          end else begin
            out_valid_r <= 1'b1;
            state_r     <= ST_OUTPUT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          pc_r        <= '0;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.imem_addr = pc_r;
  assign bus.fetch     = fetch_r;
  assign bus.dram_addr = dram_addr_s;
  assign bus.cram_addr = cram_addr_s;
  assign bus.mac_clr   = mac_clr_r;
  assign bus.mac_en    = mac_en_r;
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_waddr  = result_r;
  assign bus.out_valid = out_valid_r;

endmodule : ctrl_sequencer

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter IAWIDTH, 6: instruction memory address width.
REQ-002 Parameter DAWIDTH, 12: data/coefficient RAM address width; matches the instruction-fetch pointer fields.
REQ-003 Parameter RFAWIDTH, 5: register file address width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low; no other reset exists.
REQ-006 start  in  1  new input sample available; one-cycle pulse.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 imem_addr  out  IAWIDTH  program counter presented to instruction memory.
REQ-009 fetch  out  1  instruction-fetch strobe.
REQ-010 lstg_f, upse_f  in  1 each  decoded last-stage and last-vector flags from the fetch stage.
REQ-011 result_reg  in  RFAWIDTH  decoded result register address.
REQ-012 data_uptr, data_lptr, coef_ptr  in  DAWIDTH each  decoded pointers.
REQ-013 dram_addr, cram_addr  out  DAWIDTH each  data and coefficient RAM read addresses.
REQ-014 mac_clr, mac_en  out  1 each  accumulator clear and accumulate enables.
REQ-015 rf_we  out  1; rf_waddr  out  RFAWIDTH  result write to the register file.
REQ-016 out_valid  out  1; out_ready  in  1  output-sample handshake.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, LOAD, DECODE, MAC, WRITE and OUTPUT.
REQ-018 IDLE SHALL go to FETCH on start=1; start SHALL be ignored in every other state.
REQ-019 FETCH SHALL drive fetch=1 for exactly one cycle with imem_addr=pc, then go to LOAD.
REQ-020 LOAD SHALL be one wait cycle covering the synchronous memory read plus the fetch-stage register, then go to DECODE.
REQ-021 DECODE SHALL set dram_addr=data_lptr, cram_addr=coef_ptr and tap count N=(data_uptr-data_lptr) mod 2^DAWIDTH + 1, latch result_reg, lstg_f and upse_f, then go to MAC.
REQ-022 MAC SHALL last exactly N cycles with mac_en=1; mac_clr=1 only in the first MAC cycle; both addresses SHALL increment by 1 per cycle, modulo 2^DAWIDTH.
REQ-023 The last MAC cycle SHALL be the one where dram_addr equals data_uptr; the FSM SHALL then go to WRITE.
REQ-024 WRITE SHALL assert rf_we for one cycle with rf_waddr equal to the latched result_reg.
REQ-025 After WRITE, the FSM SHALL go to OUTPUT if latched upse_f=1; otherwise it SHALL advance the program counter.
REQ-026 OUTPUT SHALL hold out_valid=1 until the cycle out_ready=1, then advance the program counter; out_valid SHALL fall the following cycle.
REQ-027 Program counter advance: if latched lstg_f=1, pc becomes 0 and the state becomes IDLE; otherwise pc=pc+1 modulo 2^IAWIDTH and the state becomes FETCH.
REQ-028 If data_uptr=data_lptr, then N=1: one MAC cycle with mac_clr=1 and mac_en=1 together.
REQ-029 data_lptr>data_uptr SHALL wrap through address 2^DAWIDTH-1 to 0; coefficient addresses SHALL wrap identically.
REQ-030 out_ready=1 in the same cycle out_valid first rises SHALL complete the handshake in that cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, pc=0 and every output to 0, including mid-MAC and mid-OUTPUT; the latched flags SHALL be cleared.
REQ-032 After rst_n deasserts, the first rising edge SHALL sample start normally.

Structure
REQ-033 Package ctrl_pkg SHALL hold the FSM state encoding and the default widths IAWIDTH, DAWIDTH and RFAWIDTH.
REQ-034 One sub-module, ctrl_agen, SHALL hold the modulo address counters, the tap counter and the last-tap detection; the FSM SHALL remain in ctrl_sequencer.

Verification
REQ-035 Pointers lptr=0x010, uptr=0x013, cptr=0x100, lstg=1, upse=1 -> 4 MAC cycles with dram_addr 0x010..0x013 and cram_addr 0x100..0x103, then one rf_we pulse, then out_valid, then IDLE with pc=0.
REQ-036 lptr=0xFFE, uptr=0x001 -> 4 MAC cycles with dram_addr 0xFFE, 0xFFF, 0x000, 0x001.
REQ-037 Three instructions, the last with lstg=1, only the middle one with upse=1 -> imem_addr 0, 1, 2; exactly one out_valid; with out_ready held low 5 cycles, out_valid holds 5 cycles and then completes.
REQ-038 uptr=lptr=0x020 -> a single MAC cycle with mac_clr=mac_en=1; start pulsed during MAC is ignored (pc unchanged afterwards).
REQ-039 rst_n low in the second MAC cycle -> busy, mac_en and rf_we are 0 before the next clock edge; after release, start restarts from imem_addr=0.
